ahb2apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge: accepts AHB single and burst reads/writes and converts each beat into a two-phase APB transfer (SETUP, then ENABLE) to one of three APB slaves.
- Sits between the system AHB master and the APB peripheral interface.
- Internally: AHB slave front end (pipeline registers, address decode, valid) plus an APB controller FSM.

---
 rtl/ahb2apb_bridge.sv | 170 +++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge.
// An AHB front end pipelines address/data and qualifies each beat, and an
// eight-state controller turns every accepted beat into an APB SETUP/ENABLE
// pair toward one of three slaves. All APB outputs are registered.
module ahb2apb_bridge (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hwrite,
   input  logic        hreadyin,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   input  logic [31:0] haddr,
   input  logic [31:0] prdata,
   output logic        penable,
   output logic        pwrite,
   output logic        hreadyout,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic [31:0] hrdata,
   output logic [2:0]  pselx,
   output logic [1:0]  hresp
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_READ,
      ST_WRITE,
      ST_WRITEP,
      ST_RENABLE,
      ST_WENABLE,
      ST_WENABLEP
   } state_t;

   state_t      state_q, state_d;

   logic [31:0] haddr1_q, haddr2_q, hwdata1_q;
   logic        hwrite_q;

   logic        valid;
   logic [2:0]  tempselx;

   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        pwrite_q, pwrite_d;
   logic [2:0]  pselx_q, pselx_d;
   logic        penable_q, penable_d;
   logic        hreadyout_q, hreadyout_d;

   // Front-end pipeline: delayed address/data feed the buffered-write paths.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         haddr1_q  <= '0;
         haddr2_q  <= '0;
         hwdata1_q <= '0;
         hwrite_q  <= 1'b0;
      end else begin
         haddr1_q  <= haddr;
         haddr2_q  <= haddr1_q;
         hwdata1_q <= hwdata;
         hwrite_q  <= hwrite;
      end
   end

   // Beat qualification and slave decode from the live address phase.
   always_comb begin
      valid    = hreadyin && (htrans == 2'b10 || htrans == 2'b11) &&
                 (haddr >= 32'h8000_0000) && (haddr < 32'h8C00_0000);
      tempselx = 3'b000;
      case (haddr[31:26])
         6'b100000: tempselx = 3'b001;
         6'b100001: tempselx = 3'b010;
         6'b100010: tempselx = 3'b100;
         default:   tempselx = 3'b000;
      endcase
   end

   // Controller next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     state_d = !valid ? ST_IDLE : (hwrite ? ST_WWAIT : ST_READ);
         ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
         ST_READ:     state_d = ST_RENABLE;
         ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
         ST_WRITEP:   state_d = ST_WENABLEP;
         ST_RENABLE,
         ST_WENABLE:  state_d = !valid ? ST_IDLE : (hwrite ? ST_WWAIT : ST_READ);
         ST_WENABLEP: state_d = !hwrite_q ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output loads chosen by the transition being taken; default is hold.
   always_comb begin
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      pselx_d     = pselx_q;
      penable_d   = penable_q;
      hreadyout_d = hreadyout_q;
      if (state_d == ST_READ) begin
         paddr_d     = haddr;
         pwrite_d    = 1'b0;
         pselx_d     = tempselx;
         penable_d   = 1'b0;
         hreadyout_d = 1'b0;
      end else if (state_d == ST_WWAIT || state_d == ST_IDLE) begin
         pselx_d     = 3'b000;
         penable_d   = 1'b0;
         hreadyout_d = 1'b1;
      end else if (state_d == ST_WRITE || state_d == ST_WRITEP) begin
         // First beat takes the one-cycle-old address with live data; later
         // beats come from one stage further back in the pipeline.
         if (state_q == ST_WWAIT) begin
            paddr_d  = haddr1_q;
            pwdata_d = hwdata;
         end else begin
            paddr_d  = haddr2_q;
            pwdata_d = hwdata1_q;
         end
         pwrite_d    = 1'b1;
         pselx_d     = tempselx;
         penable_d   = 1'b0;
         hreadyout_d = 1'b0;
      end else if (state_q == ST_WRITE && state_d == ST_WENABLEP) begin
         paddr_d     = haddr1_q;
         pwdata_d    = hwdata;
         pwrite_d    = 1'b1;
         pselx_d     = tempselx;
         penable_d   = 1'b0;
         hreadyout_d = 1'b0;
      end else if (state_d == ST_RENABLE || state_d == ST_WENABLE ||
                   state_d == ST_WENABLEP) begin
         penable_d   = 1'b1;
         hreadyout_d = 1'b1;
      end
   end

   // State and registered APB/AHB outputs.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         pselx_q     <= 3'b000;
         penable_q   <= 1'b0;
         hreadyout_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         hreadyout_q <= hreadyout_d;
      end
   end

   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign pwrite    = pwrite_q;
   assign pselx     = pselx_q;
   assign penable   = penable_q;
   assign hreadyout = hreadyout_q;
   assign hrdata    = prdata;
   assign hresp     = 2'b00;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge: stimulus pushes expected APB phases,
// a negedge monitor pops and compares whenever a slave select is active.
module tb_ahb2apb_bridge;

   logic        hclk = 1'b0;
   logic        hresetn, hwrite, hreadyin;
   logic [1:0]  htrans;
   logic [31:0] hwdata, haddr, prdata;
   logic        penable, pwrite, hreadyout;
   logic [31:0] paddr, pwdata, hrdata;
   logic [2:0]  pselx;
   logic [1:0]  hresp;

   always #5 hclk = ~hclk;

   ahb2apb_bridge dut (
      .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hreadyin(hreadyin),
      .htrans(htrans), .hwdata(hwdata), .haddr(haddr), .prdata(prdata),
      .penable(penable), .pwrite(pwrite), .hreadyout(hreadyout),
      .paddr(paddr), .pwdata(pwdata), .hrdata(hrdata), .pselx(pselx),
      .hresp(hresp)
   );

   typedef struct {
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic [31:0] hrdata;
      logic        pwrite;
      logic        penable;
      logic        hreadyout;
      logic [2:0]  pselx;
      bit          chk_w;
      bit          chk_r;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;

   localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_phase(input logic [31:0] a, input logic [31:0] d, input logic [31:0] r,
                             input logic w, input logic en, input logic rdy,
                             input logic [2:0] sel, input bit cw, input bit cr);
      exp_t e;
      e.paddr = a; e.pwdata = d; e.hrdata = r; e.pwrite = w; e.penable = en;
      e.hreadyout = rdy; e.pselx = sel; e.chk_w = cw; e.chk_r = cr;
      exp_q.push_back(e);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [2:0] sel, input logic [31:0] d);
      push_phase(a, d, 32'h0, 1'b1, 1'b0, 1'b0, sel, 1'b1, 1'b0);
      push_phase(a, d, 32'h0, 1'b1, 1'b1, 1'b1, sel, 1'b1, 1'b0);
   endtask

   task automatic push_rd(input logic [31:0] a, input logic [2:0] sel, input logic [31:0] r);
      push_phase(a, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, sel, 1'b0, 1'b0);
      push_phase(a, 32'h0, r, 1'b0, 1'b1, 1'b1, sel, 1'b0, 1'b1);
   endtask

   // One bus cycle of master stimulus, applied just after the clock edge.
   task automatic drive(input logic [1:0] tr, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] pr);
      htrans = tr; hwrite = w; haddr = a; hwdata = d; prdata = pr;
      @(posedge hclk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_paddr"}, paddr, 32'h0);
      check({tag, "_pwdata"}, pwdata, 32'h0);
      check({tag, "_pwrite"}, {31'h0, pwrite}, 32'h0);
      check({tag, "_pselx"}, {29'h0, pselx}, 32'h0);
      check({tag, "_penable"}, {31'h0, penable}, 32'h0);
      check({tag, "_hreadyout"}, {31'h0, hreadyout}, 32'h1);
   endtask

   // Monitor: every active select must match the next expected APB phase;
   // with no select active the bridge must be quiet and ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge hclk);
         if (mon_en) begin
            check("hresp", {30'h0, hresp}, 32'h0);
            if (pselx !== 3'b000) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_apb: got pselx=%b paddr=%h penable=%b expected no transfer",
                           pselx, paddr, penable);
               end else begin
                  e = exp_q.pop_front();
                  $display("APB %s %s paddr=%h pwdata=%h hrdata=%h pselx=%b hreadyout=%b",
                           penable ? "ENABLE" : "SETUP ", pwrite ? "WR" : "RD",
                           paddr, pwdata, hrdata, pselx, hreadyout);
                  check("paddr", paddr, e.paddr);
                  check("pselx", {29'h0, pselx}, {29'h0, e.pselx});
                  check("pwrite", {31'h0, pwrite}, {31'h0, e.pwrite});
                  check("penable", {31'h0, penable}, {31'h0, e.penable});
                  check("hreadyout", {31'h0, hreadyout}, {31'h0, e.hreadyout});
                  if (e.chk_w) check("pwdata", pwdata, e.pwdata);
                  if (e.chk_r) check("hrdata", hrdata, e.hrdata);
               end
            end else begin
               check("idle_penable", {31'h0, penable}, 32'h0);
               check("idle_hreadyout", {31'h0, hreadyout}, 32'h1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of test expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      hresetn = 1'b0; hreadyin = 1'b1; hwrite = 1'b0; htrans = IDLE;
      haddr = '0; hwdata = '0; prdata = '0;
      repeat (2) @(posedge hclk);
      #1;
      check_reset_state("reset");
      hresetn = 1'b1;
      mon_en  = 1'b1;
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Single write.
      push_wr(32'h8000_0000, 3'b001, 32'h0000_00A5);
      drive(NSEQ, 1'b1, 32'h8000_0000, 32'h0, 32'h0);
      drive(IDLE, 1'b1, 32'h8000_0000, 32'h0000_00A5, 32'h0);
      drive(IDLE, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Single read.
      push_rd(32'h8400_0010, 3'b010, 32'h1234_5678);
      drive(NSEQ, 1'b0, 32'h8400_0010, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h8400_0010, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h1234_5678);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Wrap-4 burst write through the buffered-write path.
      push_wr(32'h8800_0008, 3'b100, 32'hD000_0008);
      push_wr(32'h8800_000C, 3'b100, 32'hD100_000C);
      push_wr(32'h8800_0000, 3'b100, 32'hD200_0000);
      push_wr(32'h8800_0004, 3'b100, 32'hD300_0004);
      drive(NSEQ, 1'b1, 32'h8800_0008, 32'h0, 32'h0);
      drive(SEQ,  1'b1, 32'h8800_000C, 32'hD000_0008, 32'h0);
      drive(SEQ,  1'b1, 32'h8800_0000, 32'hD100_000C, 32'h0);
      drive(SEQ,  1'b1, 32'h8800_0000, 32'hD100_000C, 32'h0);
      drive(SEQ,  1'b1, 32'h8800_0004, 32'hD200_0000, 32'h0);
      drive(SEQ,  1'b1, 32'h8800_0004, 32'hD200_0000, 32'h0);
      drive(IDLE, 1'b1, 32'h8800_0004, 32'hD300_0004, 32'h0);
      drive(IDLE, 1'b1, 32'h8800_0004, 32'hD300_0004, 32'h0);
      drive(IDLE, 1'b0, 32'h8800_0004, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Wrap-4 burst read.
      push_rd(32'h8000_0004, 3'b001, 32'hAAAA_0004);
      push_rd(32'h8000_0008, 3'b001, 32'hBBBB_0008);
      push_rd(32'h8000_000C, 3'b001, 32'hCCCC_000C);
      push_rd(32'h8000_0000, 3'b001, 32'hDDDD_0000);
      drive(NSEQ, 1'b0, 32'h8000_0004, 32'h0, 32'h0);
      drive(SEQ,  1'b0, 32'h8000_0008, 32'h0, 32'h0);
      drive(SEQ,  1'b0, 32'h8000_0008, 32'h0, 32'hAAAA_0004);
      drive(SEQ,  1'b0, 32'h8000_000C, 32'h0, 32'h0);
      drive(SEQ,  1'b0, 32'h8000_000C, 32'h0, 32'hBBBB_0008);
      drive(SEQ,  1'b0, 32'h8000_0000, 32'h0, 32'h0);
      drive(SEQ,  1'b0, 32'h8000_0000, 32'h0, 32'hCCCC_000C);
      drive(IDLE, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'hDDDD_0000);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Last word of the decoded window.
      push_rd(32'h8BFF_FFFC, 3'b100, 32'hCAFE_F00D);
      drive(NSEQ, 1'b0, 32'h8BFF_FFFC, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Transfers that must not reach APB.
      drive(NSEQ, 1'b1, 32'h9000_0000, 32'h0, 32'h0);
      drive(IDLE, 1'b1, 32'h9000_0000, 32'h5555_5555, 32'h0);
      drive(IDLE, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      drive(BUSY, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      drive(NSEQ, 1'b0, 32'h8C00_0000, 32'h0, 32'h0);
      drive(NSEQ, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0);
      hreadyin = 1'b0;
      drive(NSEQ, 1'b0, 32'h8000_0000, 32'h0, 32'h0);
      hreadyin = 1'b1;
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      // Reset asserted while a read is in its SETUP cycle.
      push_phase(32'h8000_0020, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
      drive(NSEQ, 1'b0, 32'h8000_0020, 32'h0, 32'h0);
      hresetn = 1'b0;
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      check_reset_state("midreset");
      hresetn = 1'b1;
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);
      drive(IDLE, 1'b0, 32'h0, 32'h0, 32'h0);

      check("queue_drained", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
